// File: rtl/riscboy_ppu_sprite_sched_pkg.sv
// Shared PPU constants for the sprite scheduler: sprite-table word layout and FSM encodings.
package riscboy_ppu_sprite_sched_pkg;
    localparam int TW_X_LSB    = 0;
    localparam int TW_Y_LSB    = 9;
    localparam int TW_TILE_LSB = 18;
    localparam int TW_TILE_W   = 8;
    localparam int TW_EN_BIT   = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;
endpackage

// File: rtl/riscboy_ppu_sprite_slotbuf.sv
// Shadow slots filled during a scan, live slots presented to the sprite AGU, and the fill pointer.
module riscboy_ppu_sprite_slotbuf
    import riscboy_ppu_sprite_sched_pkg::*;
#(
    parameter int W_COORD = 9,
    parameter int N_SLOT  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clear,
    input  logic                        i_push,
    input  logic [W_COORD-1:0]          i_x,
    input  logic [W_COORD-1:0]          i_y,
    input  logic [TW_TILE_W-1:0]        i_tile,
    input  logic                        i_commit,
    input  logic                        i_kill,
    output logic                        o_full,
    output logic [N_SLOT*W_COORD-1:0]   o_pos_x,
    output logic [N_SLOT*W_COORD-1:0]   o_pos_y,
    output logic [N_SLOT*TW_TILE_W-1:0] o_tile,
    output logic [N_SLOT-1:0]           o_valid
);
    localparam int W_FILL = $clog2(N_SLOT + 1);

    logic [W_FILL-1:0] r_fill;

    assign o_full = (r_fill == W_FILL'(N_SLOT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fill <= '0;
        else if (i_clear)
            r_fill <= '0;
        else if (i_push && !o_full)
            r_fill <= r_fill + 1'b1;
    end

    for (genvar s = 0; s < N_SLOT; s++) begin : g_slot
        logic [W_COORD-1:0]   r_sh_x, r_sh_y, r_lv_x, r_lv_y;
        logic [TW_TILE_W-1:0] r_sh_t, r_lv_t;
        logic                 r_sh_v, r_lv_v;
        logic                 w_sel;

        assign w_sel = i_push && (r_fill == W_FILL'(s));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sh_x <= '0; r_sh_y <= '0; r_sh_t <= '0; r_sh_v <= 1'b0;
                r_lv_x <= '0; r_lv_y <= '0; r_lv_t <= '0; r_lv_v <= 1'b0;
            end else begin
                if (i_clear) begin
                    r_sh_x <= '0; r_sh_y <= '0; r_sh_t <= '0; r_sh_v <= 1'b0;
                end else if (w_sel) begin
                    r_sh_x <= i_x; r_sh_y <= i_y; r_sh_t <= i_tile; r_sh_v <= 1'b1;
                end
                // Commit samples the shadow as it stood before this edge's clear/push.
                if (i_commit) begin
                    r_lv_x <= r_sh_x; r_lv_y <= r_sh_y; r_lv_t <= r_sh_t; r_lv_v <= r_sh_v;
                end else if (i_kill) begin
                    r_lv_v <= 1'b0;
                end
            end
        end

        assign o_pos_x[s*W_COORD +: W_COORD]     = r_lv_x;
        assign o_pos_y[s*W_COORD +: W_COORD]     = r_lv_y;
        assign o_tile[s*TW_TILE_W +: TW_TILE_W]  = r_lv_t;
        assign o_valid[s]                        = r_lv_v;
    end
endmodule

// File: rtl/riscboy_ppu_sprite_sched.sv
// Sprite scheduler: scans the sprite table for one scanline and hands up to N_SLOT hits to the AGU.
module riscboy_ppu_sprite_sched
    import riscboy_ppu_sprite_sched_pkg::*;
#(
    parameter int W_COORD = 9,
    parameter int N_SLOT  = 8,
    parameter int N_TABLE = 64,
    parameter int W_IDX   = $clog2(N_TABLE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      line_start,
    input  logic                      line_swap,
    input  logic [W_COORD-1:0]        beam_y,
    input  logic                      cfg_sprite_tilesize,
    output logic                      table_ren,
    output logic [W_IDX-1:0]          table_raddr,
    input  logic [31:0]               table_rdata,
    output logic [N_SLOT*W_COORD-1:0] slot_pos_x,
    output logic [N_SLOT*W_COORD-1:0] slot_pos_y,
    output logic [N_SLOT*8-1:0]       slot_tile,
    output logic [N_SLOT-1:0]         slot_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      late
);
    localparam logic [W_IDX:0] CNT_END = (W_IDX+1)'(N_TABLE);

    sched_state_t r_state, w_state_nxt;
    logic [W_IDX:0]     r_cnt;
    logic               r_vld;
    logic [W_COORD-1:0] r_beam_y;
    logic               r_tilesize;
    logic               r_overflow, r_late;

    logic               w_start, w_ren, w_eval, w_last, w_hit, w_full;
    logic [W_COORD-1:0] w_x, w_y;
    logic [7:0]         w_tile;
    logic [W_COORD:0]   w_sum;

    assign w_start = line_start && en;
    assign w_ren   = (r_state == ST_SCAN) && (r_cnt < CNT_END);
    // r_vld marks table_rdata as belonging to a read issued in the current scan.
    assign w_eval  = (r_state == ST_SCAN) && r_vld && !w_start;
    assign w_last  = (r_cnt == CNT_END);

    assign w_x    = table_rdata[TW_X_LSB +: W_COORD];
    assign w_y    = table_rdata[TW_Y_LSB +: W_COORD];
    assign w_tile = table_rdata[TW_TILE_LSB +: TW_TILE_W];
    // One extra bit so beam_y near the top of the coordinate range cannot wrap into a hit.
    assign w_sum  = {1'b0, r_beam_y} + (r_tilesize ? (W_COORD+1)'(16) : (W_COORD+1)'(8));
    assign w_hit  = w_eval && table_rdata[TW_EN_BIT] && (r_beam_y < w_y)
                    && (w_sum >= {1'b0, w_y});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (w_start)
                    w_state_nxt = ST_SCAN;
                else if ((w_hit && w_full) || (w_eval && w_last))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = w_start ? ST_SCAN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_vld      <= 1'b0;
            r_beam_y   <= '0;
            r_tilesize <= 1'b0;
            r_overflow <= 1'b0;
            r_late     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vld   <= w_ren && !w_start;
            if (w_start) begin
                r_cnt      <= '0;
                r_beam_y   <= beam_y;
                r_tilesize <= cfg_sprite_tilesize;
                r_overflow <= 1'b0;
            end else begin
                if (w_ren)
                    r_cnt <= r_cnt + 1'b1;
                if (w_hit && w_full)
                    r_overflow <= 1'b1;
            end
            if (line_swap)
                r_late <= busy;
        end
    end

    riscboy_ppu_sprite_slotbuf #(
        .W_COORD (W_COORD),
        .N_SLOT  (N_SLOT)
    ) u_slotbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_start),
        .i_push   (w_hit && !w_full),
        .i_x      (w_x),
        .i_y      (w_y),
        .i_tile   (w_tile),
        .i_commit (line_swap && !busy),
        .i_kill   (line_swap && busy),
        .o_full   (w_full),
        .o_pos_x  (slot_pos_x),
        .o_pos_y  (slot_pos_y),
        .o_tile   (slot_tile),
        .o_valid  (slot_valid)
    );

    assign table_ren   = w_ren;
    assign table_raddr = r_cnt[W_IDX-1:0];
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign overflow    = r_overflow;
    assign late        = r_late;
endmodule
